mii_net_tx_fcs: RTL and testbench
=================================

MII_NET_TX_FCS -- requirements
Module: mii_net_tx_fcs

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60: minimum bytes before FCS; shorter frames are zero-padded; 0 disables padding.
REQ-002 SHALL have parameter IFG_CYCLES, default 12: idle cycles enforced after each frame's last FCS byte.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port i_data, input, 8: upstream frame byte (destination MAC through payload, no preamble/SFD).
REQ-006 SHALL have port i_valid, input, 1: upstream byte valid.
REQ-007 SHALL have port i_last, input, 1: qualifies i_data as the final payload byte.
REQ-008 SHALL have port o_ready, output, 1: block accepts the upstream byte this cycle.
REQ-009 SHALL have port o_data, output, 8: downstream byte (payload, pad or FCS).
REQ-010 SHALL have port o_valid, output, 1: o_data valid.
REQ-011 SHALL have port o_last, output, 1: o_data is the final FCS byte.
REQ-012 SHALL have port i_ready, input, 1: downstream accepts o_data.
REQ-013 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse when IFG completes.

Function
REQ-015 SHALL instantiate mii_net_crc32 and sequence it: i_init on frame start, i_calc+i_d_valid per payload/pad byte, then four FCS bytes.
REQ-016 SHALL implement states IDLE, DATA, PAD, FCS, IFG.
REQ-017 SHALL use a single registered output stage; "slot free" = !o_valid || i_ready.
REQ-018 SHALL drive o_ready = (state IDLE or DATA) && slot free; o_ready low in PAD, FCS, IFG.
REQ-019 SHALL load an accepted upstream byte into o_data with o_valid high on the next cycle (latency 1).
REQ-020 SHALL hold o_data/o_valid/o_last stable while o_valid && !i_ready.
REQ-021 IDLE: first accepted byte SHALL move to DATA, pulse CRC init, and include that byte in the CRC.
REQ-022 SHALL fold every byte loaded into the output register in DATA and PAD into the CRC exactly once, in order.
REQ-023 SHALL keep an 11-bit byte counter of payload+pad bytes loaded; cleared at frame start; saturates at 2047.
REQ-024 On accepting the i_last byte: SHALL go to PAD if count (including that byte) < MIN_FRAME, else FCS.
REQ-025 PAD: SHALL load 0x00 each slot-free cycle until count == MIN_FRAME, then go to FCS.
REQ-026 FCS: SHALL load four bytes = ~CRC32 (IEEE 802.3, reflected, init 0xFFFFFFFF), least-significant byte first, one per slot-free cycle.
REQ-027 SHALL set o_last only with the fourth FCS byte.
REQ-028 SHALL enter IFG when the fourth FCS byte transfers (o_valid && i_ready).
REQ-029 IFG: SHALL count IFG_CYCLES cycles, then pulse o_done and return to IDLE; IFG_CYCLES = 0 returns to IDLE on the next cycle with o_done.
REQ-030 SHALL ignore i_last when !i_valid.
REQ-031 A single-byte frame (i_last on first byte) SHALL be legal: IDLE -> PAD/FCS directly.
REQ-032 Downstream stall (i_ready low) in any state SHALL freeze the counter, CRC and state progression without loss or duplication.

Reset
REQ-033 On i_reset, immediately and asynchronously: state IDLE, o_valid=0, o_last=0, o_data=0x00, o_busy=0, o_done=0, counters 0; o_ready low while reset is asserted.
REQ-034 SHALL reset the CRC instance on i_reset; reset mid-frame discards the frame, and the next frame's FCS equals that of a fresh frame.

Verification
REQ-035 MIN_FRAME=0, IFG_CYCLES=0, i_ready=1, bytes 0x31..0x39 ("123456789") with i_last on 0x39 -> output 31..39, 26, 39, F4, CB; o_last only on CB; o_done one cycle later.
REQ-036 Default parameters, 14-byte frame -> 46 bytes of 0x00 pad, 60 data bytes total, then 4 FCS bytes matching a software CRC32 of the 60 bytes; 64 transfers total.
REQ-037 60-byte frame with default MIN_FRAME -> no pad; FCS immediately follows byte 60.
REQ-038 Random i_ready toggling (50%) during DATA, PAD and FCS -> output byte sequence identical to the i_ready=1 run; o_data stable while stalled.
REQ-039 After o_last transfers, default IFG -> o_ready low for exactly 12 cycles; o_done pulses once; the next frame is then accepted.
REQ-040 i_reset asserted at byte 20 of a frame -> outputs clear the same cycle; the following "123456789" frame (MIN_FRAME=0) still ends 26 39 F4 CB.

Source files
------------

// File: rtl/mii_net_tx_fcs.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mii_net_crc32
//   Byte-wide IEEE 802.3 CRC32 accumulator (reflected, poly 0xEDB88320).
//   i_init reseeds to 0xFFFFFFFF; when i_calc && i_d_valid the byte is folded
//   in on the same edge, so an init and the first byte may share a cycle.
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_init                reseed the accumulator
//   i_calc, i_d_valid     fold i_data into the accumulator
//   i_data [7:0]          byte to fold
//   o_crc  [31:0]         raw accumulator (FCS is its complement)
// -----------------------------------------------------------------------------
module mii_net_crc32 (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_init,
  input  logic        i_calc,
  input  logic        i_d_valid,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] seed;

  always_comb begin
    seed  = i_init ? 32'hFFFF_FFFF : crc_q;
    crc_d = seed;
    if (i_calc && i_d_valid) begin
      crc_d = seed ^ {24'd0, i_data};
      for (int b = 0; b < 8; b++) begin
        crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB8_8320) : (crc_d >> 1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) crc_q <= 32'hFFFF_FFFF;
    else         crc_q <= crc_d;
  end

  assign o_crc = crc_q;
endmodule

// -----------------------------------------------------------------------------
// mii_net_tx_fcs
//   Transmit framer: passes upstream frame bytes through a single registered
//   output stage, zero-pads short frames up to MIN_FRAME bytes, appends the
//   4-byte FCS (LSB first) and then holds off for IFG_CYCLES idle cycles.
// Ports:
//   i_clk, i_reset              clock, async active-high reset
//   i_data/i_valid/i_last       upstream byte stream, o_ready back-pressure
//   o_data/o_valid/o_last       downstream byte stream, i_ready back-pressure
//   o_busy                      FSM not in IDLE
//   o_done                      one-cycle pulse in the final IFG cycle
//   o_dbg_state [2:0]           current FSM state encoding
//
// Handshake: a byte moves on an edge where its valid and the receiver's ready
// are both high. Upstream o_ready is combinational from registered state and
// i_ready; downstream o_data/o_valid/o_last are registered and held unchanged
// while o_valid && !i_ready.
// -----------------------------------------------------------------------------
module mii_net_tx_fcs #(
  parameter int MIN_FRAME  = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAD  = 3'd2,
    S_FCS  = 3'd3,
    S_IFG  = 3'd4
  } state_e;

  localparam logic [11:0] MIN_F      = 12'(MIN_FRAME);
  localparam int          IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int          IFG_LAST_I = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_LAST_I);
  localparam logic        IFG_SHORT  = (IFG_CYCLES <= 1);

  state_e           state_q;
  logic [10:0]      cnt_q;
  logic [2:0]       fcs_cnt_q;
  logic [IFG_W-1:0] ifg_cnt_q;
  logic [7:0]       o_data_q;
  logic             o_valid_q;
  logic             o_last_q;
  logic             o_done_q;

  logic        slot_free;
  logic        accept;
  logic        pad_load;
  logic        crc_init;
  logic        crc_calc;
  logic [7:0]  crc_in;
  logic [10:0] cnt_base;
  logic [10:0] cnt_plus;
  logic [31:0] crc_q;
  logic [31:0] fcs_val;
  logic [7:0]  fcs_byte;

  assign slot_free = !o_valid_q || i_ready;
  assign o_ready   = !i_reset && slot_free && (state_q == S_IDLE || state_q == S_DATA);
  assign accept    = i_valid && o_ready;
  assign pad_load  = (state_q == S_PAD) && slot_free;

  // CRC follows exactly the bytes written into the output register.
  assign crc_init = accept && (state_q == S_IDLE);
  assign crc_calc = accept || pad_load;
  assign crc_in   = accept ? i_data : 8'h00;

  // A new frame counts from zero regardless of what cnt_q holds in IDLE.
  assign cnt_base = (state_q == S_IDLE) ? 11'd0 : cnt_q;
  assign cnt_plus = (cnt_base == 11'h7FF) ? cnt_base : cnt_base + 11'd1;

  assign fcs_val = ~crc_q;
  always_comb begin
    fcs_byte = fcs_val[7:0];
    case (fcs_cnt_q[1:0])
      2'd0:    fcs_byte = fcs_val[7:0];
      2'd1:    fcs_byte = fcs_val[15:8];
      2'd2:    fcs_byte = fcs_val[23:16];
      default: fcs_byte = fcs_val[31:24];
    endcase
  end

  mii_net_crc32 u_crc (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_init    (crc_init),
    .i_calc    (crc_calc),
    .i_d_valid (crc_calc),
    .i_data    (crc_in),
    .o_crc     (crc_q)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      fcs_cnt_q <= 3'd0;
      ifg_cnt_q <= '0;
      o_data_q  <= 8'h00;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_done_q  <= 1'b0;
    end else begin
      o_done_q <= 1'b0;
      // A free slot empties the register unless a state below reloads it.
      if (slot_free) begin
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_DATA: begin
          if (accept) begin
            o_data_q  <= i_data;
            o_valid_q <= 1'b1;
            cnt_q     <= cnt_plus;
            fcs_cnt_q <= 3'd0;
            if (i_last) state_q <= ({1'b0, cnt_plus} < MIN_F) ? S_PAD : S_FCS;
            else        state_q <= S_DATA;
          end
        end
        S_PAD: begin
          if (slot_free) begin
            o_data_q  <= 8'h00;
            o_valid_q <= 1'b1;
            cnt_q     <= cnt_plus;
            if ({1'b0, cnt_plus} >= MIN_F) state_q <= S_FCS;
          end
        end
        S_FCS: begin
          // Leave only once the fourth byte has actually been taken.
          if (o_valid_q && o_last_q && i_ready) begin
            state_q   <= S_IFG;
            ifg_cnt_q <= '0;
            o_done_q  <= IFG_SHORT;
          end else if (slot_free && fcs_cnt_q != 3'd4) begin
            o_data_q  <= fcs_byte;
            o_valid_q <= 1'b1;
            o_last_q  <= (fcs_cnt_q == 3'd3);
            fcs_cnt_q <= fcs_cnt_q + 3'd1;
          end
        end
        S_IFG: begin
          // o_done is raised during the last IFG cycle, so it is visible
          // exactly once before o_ready returns.
          if (IFG_SHORT || ifg_cnt_q == IFG_LAST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 11'd0;
            fcs_cnt_q <= 3'd0;
            ifg_cnt_q <= '0;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + IFG_W'(1);
            o_done_q  <= ((ifg_cnt_q + IFG_W'(1)) == IFG_LAST);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data      = o_data_q;
  assign o_valid     = o_valid_q;
  assign o_last      = o_last_q;
  assign o_done      = o_done_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_mii_net_tx_fcs.sv
`timescale 1ns/1ps
// Bench for mii_net_tx_fcs. Two instances share the clock and reset: dut_a
// uses default parameters, dut_b uses MIN_FRAME=0 / IFG_CYCLES=0. `sel`
// routes the common stimulus to one of them and muxes its outputs back.
module tb_mii_net_tx_fcs;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       ds_ready;
  logic       sel;

  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, a_valid, b_valid, a_last, b_last;
  logic       a_busy, b_busy, a_done, b_done;
  logic [2:0] a_st, b_st;

  logic [7:0] out_data;
  logic       out_ready, out_valid, out_last, out_busy, out_done;

  always #5 clk = ~clk;

  mii_net_tx_fcs dut_a (
    .i_clk(clk), .i_reset(rst), .i_data(in_data), .i_valid(in_valid && !sel),
    .i_last(in_last), .o_ready(a_ready), .o_data(a_data), .o_valid(a_valid),
    .o_last(a_last), .i_ready(sel ? 1'b1 : ds_ready), .o_busy(a_busy),
    .o_done(a_done), .o_dbg_state(a_st)
  );

  mii_net_tx_fcs #(.MIN_FRAME(0), .IFG_CYCLES(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_data(in_data), .i_valid(in_valid && sel),
    .i_last(in_last), .o_ready(b_ready), .o_data(b_data), .o_valid(b_valid),
    .o_last(b_last), .i_ready(sel ? ds_ready : 1'b1), .o_busy(b_busy),
    .o_done(b_done), .o_dbg_state(b_st)
  );

  assign out_data  = sel ? b_data  : a_data;
  assign out_ready = sel ? b_ready : a_ready;
  assign out_valid = sel ? b_valid : a_valid;
  assign out_last  = sel ? b_last  : a_last;
  assign out_busy  = sel ? b_busy  : a_busy;
  assign out_done  = sel ? b_done  : a_done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pl_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int last_idx, stall_viol, lat_viol, ifg_low, done_cnt, done_at;
  bit timed_out;

  // Reference: pad with zeros to the minimum, CRC the padded frame bit by
  // bit, append the complement least-significant byte first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic build_expected(input int min_frame);
    logic [31:0] c;
    exp_q = pl_q;
    while (exp_q.size() < min_frame) exp_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (exp_q[i]) c = crc_step(c, exp_q[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic make_payload(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  // Drives pl_q into the selected DUT and collects downstream transfers;
  // afterwards measures the IFG window. abort_after >= 0 returns right
  // after that many bytes have been accepted (at posedge + 1).
  task automatic run_frame(input bit stall, input bit gaps, input int abort_after);
    int idx;
    bit lat_pending, prev_stall, finished;
    logic [7:0] lat_byte, prev_data;
    logic prev_last;
    got_q.delete();
    last_idx = -1; stall_viol = 0; lat_viol = 0; timed_out = 1'b0;
    ifg_low = 0; done_cnt = 0; done_at = -1;
    idx = 0; finished = 1'b0; lat_pending = 1'b0; prev_stall = 1'b0;
    lat_byte = 8'h00; prev_data = 8'h00; prev_last = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (lat_pending) idx++;
      if (abort_after >= 0 && idx == abort_after) return;
      ds_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < int'(pl_q.size()) && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; in_data = pl_q[idx]; in_last = (idx == int'(pl_q.size()) - 1);
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
      end
      @(negedge clk);
      if (lat_pending && (out_valid !== 1'b1 || out_data !== lat_byte)) lat_viol++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stall_viol++;
      lat_pending = in_valid && out_ready;
      lat_byte    = in_data;
      prev_stall  = out_valid && !ds_ready;
      prev_data   = out_data;
      prev_last   = out_last;
      if (out_valid && ds_ready) begin
        got_q.push_back(out_data);
        if (out_last) begin
          last_idx = got_q.size() - 1;
          finished = 1'b1;
        end
      end
    end
    if (!finished) begin
      timed_out = 1'b1;
      return;
    end
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      ds_ready = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      if (out_done) begin
        done_cnt++;
        if (done_at < 0) done_at = ifg_low;
      end
      if (out_ready) break;
      ifg_low++;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; ds_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %0b want 0", out_last); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %0h want 00", out_data); end
    vectors++; if (out_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", out_busy); end
    vectors++; if (out_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", out_done); end
    vectors++; if (out_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %0b want 0", out_ready); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (out_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got %0b want 1", out_ready); end
  endtask

  task automatic test_check_value();
    logic [7:0] tail [4];
    tail[0] = 8'h26; tail[1] = 8'h39; tail[2] = 8'hF4; tail[3] = 8'hCB;
    sel = 1'b1;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
    build_expected(0);
    run_frame(1'b0, 1'b0, -1);
    vectors++; if (timed_out || got_q.size() != 13) begin miscompares++; $display("FAIL chk_len got %0d want 13", got_q.size()); end
    for (int i = 0; i < 13 && i < int'(got_q.size()); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL chk_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    for (int k = 0; k < 4 && got_q.size() == 13; k++) begin
      vectors++; if (got_q[9+k] !== tail[k]) begin miscompares++; $display("FAIL chk_fcs[%0d] got %0h want %0h", k, got_q[9+k], tail[k]); end
    end
    vectors++; if (last_idx != 12) begin miscompares++; $display("FAIL chk_last_pos got %0d want 12", last_idx); end
    vectors++; if (done_at != 0 || done_cnt != 1) begin miscompares++; $display("FAIL chk_done got at=%0d n=%0d want at=0 n=1", done_at, done_cnt); end
    vectors++; if (ifg_low != 1) begin miscompares++; $display("FAIL chk_ifg got %0d want 1", ifg_low); end
  endtask

  // Shared shape for fixed-length frames through the default instance.
  task automatic test_len_default(input int n, input bit stall);
    sel = 1'b0;
    make_payload(n);
    build_expected(60);
    run_frame(stall, stall, -1);
    vectors++; if (timed_out || got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL len%0d_count got %0d want %0d", n, got_q.size(), exp_q.size()); end
    for (int i = 0; i < int'(exp_q.size()) && i < int'(got_q.size()); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL len%0d_byte[%0d] got %0h want %0h", n, i, got_q[i], exp_q[i]); end
    end
    vectors++; if (last_idx != int'(exp_q.size()) - 1) begin miscompares++; $display("FAIL len%0d_last_pos got %0d want %0d", n, last_idx, exp_q.size() - 1); end
    vectors++; if (stall_viol != 0 || lat_viol != 0) begin miscompares++; $display("FAIL len%0d_hold got stall=%0d lat=%0d want 0 0", n, stall_viol, lat_viol); end
    vectors++; if (ifg_low != 12) begin miscompares++; $display("FAIL len%0d_ifg got %0d want 12", n, ifg_low); end
    vectors++; if (done_cnt != 1 || done_at != 11) begin miscompares++; $display("FAIL len%0d_done got n=%0d at=%0d want n=1 at=11", n, done_cnt, done_at); end
  endtask

  task automatic test_pad();
    test_len_default(14, 1'b0);
    vectors++; if (got_q.size() == 64 && got_q[59] !== 8'h00) begin miscompares++; $display("FAIL pad_last_zero got %0h want 00", got_q[59]); end
  endtask

  task automatic test_no_pad();
    test_len_default(60, 1'b0);
    test_len_default(100, 1'b0);
  endtask

  task automatic test_single_byte();
    test_len_default(1, 1'b0);
    sel = 1'b1;
    make_payload(1);
    build_expected(0);
    run_frame(1'b0, 1'b0, -1);
    vectors++; if (timed_out || got_q.size() != 5) begin miscompares++; $display("FAIL single_b_len got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < int'(got_q.size()); i++) begin
      vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_b_byte[%0d] got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_random();
    int n, ifg_exp;
    for (int f = 0; f < 8; f++) begin
      sel = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 90);
      make_payload(n);
      build_expected(sel ? 0 : 60);
      ifg_exp = sel ? 1 : 12;
      run_frame(1'b1, 1'b1, -1);
      vectors++; if (timed_out || got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_count got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < int'(exp_q.size()) && i < int'(got_q.size()); i++) begin
        vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rnd%0d_byte[%0d] got %0h want %0h", f, i, got_q[i], exp_q[i]); end
      end
      vectors++; if (stall_viol != 0 || lat_viol != 0) begin miscompares++; $display("FAIL rnd%0d_hold got stall=%0d lat=%0d want 0 0", f, stall_viol, lat_viol); end
      vectors++; if (ifg_low != ifg_exp || done_cnt != 1) begin miscompares++; $display("FAIL rnd%0d_ifg got low=%0d done=%0d want low=%0d done=1", f, ifg_low, done_cnt, ifg_exp); end
    end
  endtask

  task automatic test_back_to_back();
    test_len_default(20, 1'b1);
    test_len_default(61, 1'b1);
    test_len_default(59, 1'b1);
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    make_payload(30);
    run_frame(1'b0, 1'b0, 20);
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin miscompares++; $display("FAIL midrst_out got v=%0b l=%0b d=%0h want 0 0 00", out_valid, out_last, out_data); end
    vectors++; if (out_busy !== 1'b0 || out_ready !== 1'b0 || out_done !== 1'b0) begin miscompares++; $display("FAIL midrst_ctl got busy=%0b rdy=%0b done=%0b want 0 0 0", out_busy, out_ready, out_done); end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pl_q.delete();
    for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
    build_expected(0);
    run_frame(1'b0, 1'b0, -1);
    vectors++; if (timed_out || got_q.size() != 13) begin miscompares++; $display("FAIL midrst_len got %0d want 13", got_q.size()); end
    if (got_q.size() == 13) begin
      vectors++; if ({got_q[9], got_q[10], got_q[11], got_q[12]} !== 32'h2639F4CB) begin miscompares++; $display("FAIL midrst_fcs got %0h%0h%0h%0h want 2639f4cb", got_q[9], got_q[10], got_q[11], got_q[12]); end
      vectors++; if (got_q[0] !== 8'h31 || got_q[8] !== 8'h39) begin miscompares++; $display("FAIL midrst_payload got %0h..%0h want 31..39", got_q[0], got_q[8]); end
    end
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_pad();
    test_no_pad();
    test_single_byte();
    test_stall_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
